// File: rtl/window_minmax_tracker_pkg.sv
// Shared definitions for the window min/max tracker: FSM encodings and default sizes.
package window_minmax_tracker_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int DEFAULT_N     = 16;
  localparam int DEFAULT_WIN   = 8;
  localparam int DEFAULT_IDX_W = 8;

endpackage

// File: rtl/window_minmax_tracker_cmp.sv
// Ripple magnitude comparator: unsigned a vs b, MSB-first; exactly one of g/e/l is high.
module nbit_comparator #(
  parameter int n = 16
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         g,
  output logic         e,
  output logic         l
);

  logic gt;
  logic lt;

  // NOTE: combinational logic uses blocking '=' with a default assigned first, so no latch is inferred.
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    // The first differing bit from the MSB down decides; lower bits are then ignored.
    for (int i = n - 1; i >= 0; i--) begin
      if (!gt && !lt) begin
        if (a[i] && !b[i]) gt = 1'b1;
        else if (!a[i] && b[i]) lt = 1'b1;
      end
    end
    g = gt;
    l = lt;
    e = !(gt || lt);
  end

endmodule

// File: rtl/window_minmax_tracker.sv
// Tracks max/min (with first-occurrence index) over fixed windows of WIN samples and
// presents each window's result on a valid/ready port.
module window_minmax_tracker
  import window_minmax_tracker_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIN   = DEFAULT_WIN,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_max,
  output logic [N-1:0]     out_min,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_min_idx
);

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] count, count_nxt;
  logic             out_valid_nxt;
  logic [N-1:0]     max_nxt, min_nxt;
  logic [IDX_W-1:0] max_idx_nxt, min_idx_nxt;

  logic max_g, max_e, max_l;
  logic min_g, min_e, min_l;

  nbit_comparator #(.n(N)) u_cmp_max (
    .a (in_data),
    .b (out_max),
    .g (max_g),
    .e (max_e),
    .l (max_l)
  );

  nbit_comparator #(.n(N)) u_cmp_min (
    .a (in_data),
    .b (out_min),
    .g (min_g),
    .e (min_e),
    .l (min_l)
  );

  // Strict comparisons only: a tie never displaces the earlier sample or its index.
  logic take_max, take_min;
  assign take_max = max_g && !(max_e || max_l);
  assign take_min = min_l && !(min_e || min_g);

  assign in_ready = (state != ST_HOLD);

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    out_valid_nxt = out_valid;
    max_nxt       = out_max;
    min_nxt       = out_min;
    max_idx_nxt   = out_max_idx;
    min_idx_nxt   = out_min_idx;

    if (clear) begin
      // Result fields are left alone; they are don't-care while out_valid is low.
      state_nxt     = ST_IDLE;
      count_nxt     = '0;
      out_valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            max_nxt     = in_data;
            min_nxt     = in_data;
            max_idx_nxt = '0;
            min_idx_nxt = '0;
            count_nxt   = IDX_W'(1);
            state_nxt   = ST_ACC;
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            if (take_max) begin
              max_nxt     = in_data;
              max_idx_nxt = count;
            end
            if (take_min) begin
              min_nxt     = in_data;
              min_idx_nxt = count;
            end
            if (count == IDX_W'(WIN - 1)) begin
              count_nxt     = '0;
              out_valid_nxt = 1'b1;
              state_nxt     = ST_HOLD;
            end else begin
              count_nxt = count + IDX_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            count_nxt     = '0;
            out_valid_nxt = 1'b0;
            state_nxt     = ST_IDLE;
          end
        end
        default: begin
          count_nxt     = '0;
          out_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<='; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      count       <= '0;
      out_valid   <= 1'b0;
      out_max     <= '0;
      out_min     <= '0;
      out_max_idx <= '0;
      out_min_idx <= '0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      out_valid   <= out_valid_nxt;
      out_max     <= max_nxt;
      out_min     <= min_nxt;
      out_max_idx <= max_idx_nxt;
      out_min_idx <= min_idx_nxt;
    end
  end

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Self-checking bench: queue-based window model compared every cycle, plus directed literal checks.
module tb_window_minmax_tracker;

  localparam int N     = 16;
  localparam int WIN   = 4;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_max;
  logic [N-1:0]     out_min;
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W-1:0] out_min_idx;

  int n_vec  = 0;
  int n_fail = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  window_minmax_tracker #(.N(N), .WIN(WIN), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_min     (out_min),
    .out_max_idx (out_max_idx),
    .out_min_idx (out_min_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]     win_q[$];
  bit               m_hold  = 1'b0;
  bit               m_known = 1'b0;
  logic [N-1:0]     m_max = '0, m_min = '0;
  logic [IDX_W-1:0] m_max_i = '0, m_min_i = '0;

  function automatic void scan(input logic [N-1:0] s[$],
                               output logic [N-1:0] mx, output logic [IDX_W-1:0] mxi,
                               output logic [N-1:0] mn, output logic [IDX_W-1:0] mni);
    mx = s[0]; mn = s[0]; mxi = '0; mni = '0;
    for (int k = 1; k < s.size(); k++) begin
      if (s[k] > mx) begin mx = s[k]; mxi = IDX_W'(k); end
      if (s[k] < mn) begin mn = s[k]; mni = IDX_W'(k); end
    end
  endfunction

  logic [N-1:0]     s_mx, s_mn;
  logic [IDX_W-1:0] s_mxi, s_mni;

  always @(posedge clk) begin
    if (!rst_n) begin
      win_q.delete();
      m_hold  <= 1'b0;
      m_known <= 1'b1;
      m_max <= '0; m_min <= '0; m_max_i <= '0; m_min_i <= '0;
    end else if (clear) begin
      win_q.delete();
      m_hold <= 1'b0;
    end else if (m_hold) begin
      if (out_ready) m_hold <= 1'b0;
    end else if (in_valid) begin
      win_q.push_back(in_data);
      m_known <= 1'b0;
      if (win_q.size() == WIN) begin
        scan(win_q, s_mx, s_mxi, s_mn, s_mni);
        m_max <= s_mx; m_max_i <= s_mxi; m_min <= s_mn; m_min_i <= s_mni;
        m_hold  <= 1'b1;
        m_known <= 1'b1;
        win_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      check("in_ready", 32'(in_ready), 32'(!m_hold));
      check("out_valid", 32'(out_valid), 32'(m_hold));
      if (m_known) begin
        check("out_max", 32'(out_max), 32'(m_max));
        check("out_min", 32'(out_min), 32'(m_min));
        check("out_max_idx", 32'(out_max_idx), 32'(m_max_i));
        check("out_min_idx", 32'(out_min_idx), 32'(m_min_i));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [N-1:0] d);
    bit r;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      done = r;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [N-1:0] mx, input logic [IDX_W-1:0] mxi,
                               input logic [N-1:0] mn, input logic [IDX_W-1:0] mni);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_max"}, 32'(out_max), 32'(mx));
    check({tag, "_max_idx"}, 32'(out_max_idx), 32'(mxi));
    check({tag, "_min"}, 32'(out_min), 32'(mn));
    check({tag, "_min_idx"}, 32'(out_min_idx), 32'(mni));
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_max"}, 32'(out_max), 32'd0);
    check({tag, "_min"}, 32'(out_min), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [N-1:0]     h_max, h_min;
  logic [IDX_W-1:0] h_max_i, h_min_i;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    run_chk = 1'b1;
    expect_reset_state("t0_reset");

    // 1: basic window, one-cycle latency after the last accept
    send(16'd5); send(16'd9); send(16'd3);
    check("t1_valid_before_last", 32'(out_valid), 32'd0);
    send(16'd9);
    expect_result("t1", 16'd9, 8'd1, 16'd3, 8'd2);
    release_result();

    // 2: all ties
    send(16'd7); send(16'd7); send(16'd7); send(16'd7);
    expect_result("t2", 16'd7, 8'd0, 16'd7, 8'd0);
    release_result();

    // 3: backpressure with a sample waiting
    send(16'd42); send(16'd10); send(16'd50); send(16'd10);
    h_max = out_max; h_min = out_min; h_max_i = out_max_idx; h_min_i = out_min_idx;
    in_valid = 1'b1; in_data = 16'd42;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_in_ready_held", 32'(in_ready), 32'd0);
      check("t3_valid_held", 32'(out_valid), 32'd1);
      check("t3_max_stable", 32'(out_max), 32'(h_max));
      check("t3_min_stable", 32'(out_min), 32'(h_min));
      check("t3_idx_stable", {16'd0, out_max_idx, out_min_idx}, {16'd0, h_max_i, h_min_i});
    end
    @(posedge clk); #1;
    expect_result("t3a", 16'd50, 8'd2, 16'd10, 8'd1);
    release_result();
    send(16'd42); send(16'd20); send(16'd60); send(16'd20);
    expect_result("t3b", 16'd60, 8'd2, 16'd20, 8'd1);
    release_result();

    // 4: clear mid-window drops partial samples and the sample offered with it
    send(16'd100); send(16'd200);
    in_valid = 1'b1; in_data = 16'd99; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("t4_valid_after_clear", 32'(out_valid), 32'd0);
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    expect_result("t4", 16'd4, 8'd3, 16'd1, 8'd0);
    release_result();

    // 5: reset during ACC, then during HOLD
    send(16'd300); send(16'd301);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_reset_state("t5_acc");
    send(16'd11); send(16'd12); send(16'd13); send(16'd14);
    check("t5_in_hold", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_reset_state("t5_hold");

    // 6: boundary values
    send(16'hFFFF); send(16'h0000); send(16'h8000); send(16'h0001);
    expect_result("t6", 16'hFFFF, 8'd0, 16'h0000, 8'd1);
    release_result();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_data = N'($urandom_range(0, 7));
        1:       in_data = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
        default: in_data = N'($urandom);
      endcase
      out_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 40) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
